// File: rtl/tetris_input_ctrl_pkg.sv
// Shared types and default 25 MHz timing for the Tetris input conditioning stage.
// move_t is also consumed by the game FSM.
package tetris_input_ctrl_pkg;

  typedef enum logic [2:0] {RIGHT, LEFT, ROR, ROL, DOWN, NONE} move_t;

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  // 10 ms debounce, 100 ms DAS, 25 ms ARR, 200 ms gravity at 25 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250_000;
  localparam int unsigned DEF_DAS_CYCLES      = 2_500_000;
  localparam int unsigned DEF_ARR_CYCLES      = 625_000;
  localparam int unsigned DEF_DROP_CYCLES     = 5_000_000;

  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RR    = 2;
  localparam int unsigned BTN_RL    = 3;
  localparam int unsigned BTN_EN    = 4;
  localparam int unsigned NUM_BTN   = 5;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_btn_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter, stable value and
// combinational rising-edge press strobe (registered by the consumer).
module tetris_input_ctrl_btn_debounce
  import tetris_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_press_c
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  // Stable flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_press_c = r_stable & ~r_stable_d;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Button conditioning for the Tetris game FSM: debounced press pulses,
// left/right auto-repeat, single-winner move arbitration and gravity tick.
module tetris_input_ctrl
  import tetris_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DAS_CYCLES      = DEF_DAS_CYCLES,
  parameter int unsigned ARR_CYCLES      = DEF_ARR_CYCLES,
  parameter int unsigned DROP_CYCLES     = DEF_DROP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_right_i,
  input  logic btn_left_i,
  input  logic btn_rr_i,
  input  logic btn_rl_i,
  input  logic btn_en_i,
  input  logic game_active_i,
  output logic right_o,
  output logic left_o,
  output logic rr_o,
  output logic rl_o,
  output logic en_o,
  output logic drop_tick_o
);

  localparam int unsigned RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);
  localparam int unsigned DROP_W  = cnt_width(DROP_CYCLES);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_press;
  logic [1:0]         w_rpt;
  logic [3:0]         w_ev;
  logic [3:0]         w_grant;
  logic               w_unused_stable;

  logic [3:0]         r_move;
  logic               r_en;
  logic               r_drop;
  logic [DROP_W-1:0]  r_drop_cnt;

  assign w_raw = {btn_en_i, btn_rl_i, btn_rr_i, btn_left_i, btn_right_i};

  for (genvar gi = 0; gi < int'(NUM_BTN); gi++) begin : g_db
    tetris_input_ctrl_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (w_raw[gi]),
      .o_stable (w_stable[gi]),
      .o_press_c(w_press[gi])
    );
  end

  // Only the directional buttons need their held level
  assign w_unused_stable = &{1'b0, w_stable[NUM_BTN-1:2]};

  // Auto-repeat per direction: index 0 = right, 1 = left
  for (genvar gd = 0; gd < 2; gd++) begin : g_rpt
    rpt_state_t       r_state;
    logic [RPT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= RPT_IDLE;
        r_cnt   <= '0;
      end else if (!game_active_i || !w_stable[gd]) begin
        r_state <= RPT_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          RPT_IDLE: begin
            r_cnt <= '0;
            if (w_press[gd]) r_state <= RPT_DELAY;
          end
          RPT_DELAY: begin
            if (r_cnt == RPT_W'(DAS_CYCLES - 1)) begin
              r_state <= RPT_REPEAT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + RPT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (r_cnt == RPT_W'(ARR_CYCLES - 1)) r_cnt <= '0;
            else                                 r_cnt <= r_cnt + RPT_W'(1);
          end
          default: begin
            r_state <= RPT_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_rpt[gd] = game_active_i && w_stable[gd] &&
                       (((r_state == RPT_DELAY)  && (r_cnt == RPT_W'(DAS_CYCLES - 1))) ||
                        ((r_state == RPT_REPEAT) && (r_cnt == RPT_W'(ARR_CYCLES - 1))));
  end

  assign w_ev = {w_press[BTN_RL],
                 w_press[BTN_RR],
                 w_press[BTN_LEFT]  | w_rpt[1],
                 w_press[BTN_RIGHT] | w_rpt[0]};

  // Fixed priority right > left > rr > rl; losers are dropped
  always_comb begin
    w_grant = '0;
    if      (w_ev[0]) w_grant[0] = 1'b1;
    else if (w_ev[1]) w_grant[1] = 1'b1;
    else if (w_ev[2]) w_grant[2] = 1'b1;
    else if (w_ev[3]) w_grant[3] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_move <= '0;
      r_en   <= 1'b0;
    end else begin
      r_move <= game_active_i ? w_grant : 4'b0000;
      r_en   <= w_press[BTN_EN];
    end
  end

  // Gravity restarts a full period whenever play (re)starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_drop     <= 1'b0;
    end else if (!game_active_i) begin
      r_drop_cnt <= '0;
      r_drop     <= 1'b0;
    end else if (r_drop_cnt == DROP_W'(DROP_CYCLES - 1)) begin
      r_drop_cnt <= '0;
      r_drop     <= 1'b1;
    end else begin
      r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      r_drop     <= 1'b0;
    end
  end

  assign right_o     = r_move[0];
  assign left_o      = r_move[1];
  assign rr_o        = r_move[2];
  assign rl_o        = r_move[3];
  assign en_o        = r_en;
  assign drop_tick_o = r_drop;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: directed scenarios plus random button traffic,
// all checked against a time-stamp based reference model.
module tb_tetris_input_ctrl;

  localparam int DEB  = 4;
  localparam int DAS  = 10;
  localparam int ARR  = 3;
  localparam int DROP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] raw = 5'b0;   // {en, rl, rr, left, right}
  logic       active = 1'b0;
  logic       right_o, left_o, rr_o, rl_o, en_o, drop_tick_o;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR),
    .DROP_CYCLES    (DROP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_right_i  (raw[0]),
    .btn_left_i   (raw[1]),
    .btn_rr_i     (raw[2]),
    .btn_rl_i     (raw[3]),
    .btn_en_i     (raw[4]),
    .game_active_i(active),
    .right_o      (right_o),
    .left_o       (left_o),
    .rr_o         (rr_o),
    .rl_o         (rl_o),
    .en_o         (en_o),
    .drop_tick_o  (drop_tick_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: sync = raw two edges back; stable flips when the last DEB
  // synced samples all disagree; repeats are anchored to the press edge.
  int       cyc = 0;
  bit [4:0] m_q1, m_q2, m_stable, m_rose;
  bit       m_win[5][$];
  bit       m_armed[2];
  int       m_anchor[2];
  int       m_run = 0;
  bit [4:0] m_st_pre, m_pr_pre;
  bit [1:0] m_rep;
  bit [3:0] m_ev, m_gr;
  bit [3:0] exp_move;
  bit       exp_en, exp_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_q1 = '0; m_q2 = '0; m_stable = '0; m_rose = '0; m_run = 0;
      for (int b = 0; b < 5; b++) m_win[b].delete();
      for (int d = 0; d < 2; d++) begin m_armed[d] = 0; m_anchor[d] = 0; end
      exp_move = '0; exp_en = 0; exp_drop = 0;
    end else begin
      cyc++;
      m_st_pre = m_stable;
      m_pr_pre = m_rose;
      for (int d = 0; d < 2; d++) begin
        m_rep[d] = 0;
        if (m_armed[d]) begin
          if (!active || !m_st_pre[d]) m_armed[d] = 0;
          else if ((cyc - m_anchor[d]) >= DAS && ((cyc - m_anchor[d] - DAS) % ARR) == 0)
            m_rep[d] = 1;
        end
        if (m_pr_pre[d] && active) begin m_armed[d] = 1; m_anchor[d] = cyc; end
      end
      m_ev = {m_pr_pre[3], m_pr_pre[2], m_pr_pre[1] | m_rep[1], m_pr_pre[0] | m_rep[0]};
      m_gr = '0;
      for (int i = 0; i < 4; i++) if (m_ev[i] && m_gr == 4'b0) m_gr[i] = 1;
      exp_move = active ? m_gr : 4'b0;
      exp_en   = m_pr_pre[4];
      if (active) begin m_run++; exp_drop = ((m_run % DROP) == 0); end
      else begin m_run = 0; exp_drop = 0; end
      for (int b = 0; b < 5; b++) begin
        bit all_diff;
        m_win[b].push_front(m_q2[b]);
        if (m_win[b].size() > DEB) void'(m_win[b].pop_back());
        all_diff = (m_win[b].size() == DEB);
        for (int k = 0; k < m_win[b].size(); k++)
          if (m_win[b][k] == m_stable[b]) all_diff = 0;
        m_rose[b] = 0;
        if (all_diff) begin m_stable[b] = m_q2[b]; m_rose[b] = m_q2[b]; end
      end
      m_q2 = m_q1;
      m_q1 = raw;
    end
  end

  logic [5:0] w_got, w_exp;
  assign w_got = {right_o, left_o, rr_o, rl_o, en_o, drop_tick_o};
  assign w_exp = {exp_move[0], exp_move[1], exp_move[2], exp_move[3], exp_en, exp_drop};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directional hold pattern: press at 7, first repeat at 17, then every ARR
  function automatic bit hold_hit(input int k);
    return (k == DEB + 3) || (k >= DEB + 3 + DAS && ((k - DEB - 3 - DAS) % ARR) == 0);
  endfunction

  task automatic test_reset();
    rst = 1'b1; raw = '0; active = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if (w_got !== 6'b0) $display("FAIL reset_outputs k=%0d got=%b exp=000000", k, w_got);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_rotate_single();
    active = 1'b1; raw[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      n_total++;
      if (rr_o !== hold_rr(k)) $display("FAIL rr_pulse k=%0d got=%b exp=%b", k, rr_o, hold_rr(k));
      else n_pass++;
      n_total++;
      if (w_got !== w_exp) $display("FAIL rr_model cyc=%0d got=%b exp=%b", cyc, w_got, w_exp);
      else n_pass++;
    end
    raw[2] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_total++;
      if (rr_o !== 1'b0) $display("FAIL rr_release k=%0d got=%b exp=0", k, rr_o);
      else n_pass++;
    end
  endtask

  function automatic bit hold_rr(input int k);
    return (k == DEB + 3);
  endfunction

  task automatic test_glitch_repeat();
    active = 1'b1; raw[1] = 1'b1;
    step(); step();
    raw[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_total++;
      if (left_o !== 1'b0) $display("FAIL left_glitch k=%0d got=%b exp=0", k, left_o);
      else n_pass++;
    end
    raw[1] = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      n_total++;
      if (left_o !== hold_hit(k)) $display("FAIL left_repeat k=%0d got=%b exp=%b", k, left_o, hold_hit(k));
      else n_pass++;
    end
    raw[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_total++;
      if (w_got !== w_exp) $display("FAIL left_release_model cyc=%0d got=%b exp=%b", cyc, w_got, w_exp);
      else n_pass++;
      if (k > 10) begin
        n_total++;
        if (left_o !== 1'b0) $display("FAIL left_release k=%0d got=%b exp=0", k, left_o);
        else n_pass++;
      end
    end
  endtask

  task automatic test_priority();
    active = 1'b1; raw[0] = 1'b1; raw[3] = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      n_total++;
      if (right_o !== hold_hit(k)) $display("FAIL prio_right k=%0d got=%b exp=%b", k, right_o, hold_hit(k));
      else n_pass++;
      n_total++;
      if (rl_o !== 1'b0) $display("FAIL prio_rl k=%0d got=%b exp=0", k, rl_o);
      else n_pass++;
    end
    raw = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_total++;
      if (w_got !== w_exp) $display("FAIL prio_model cyc=%0d got=%b exp=%b", cyc, w_got, w_exp);
      else n_pass++;
    end
  endtask

  task automatic test_drop();
    raw = '0; active = 1'b0;
    step(); step(); step();
    for (int k = 1; k <= 85; k++) begin
      bit exp_t;
      active = !(k >= 46 && k <= 60);
      step();
      exp_t = (k == 20) || (k == 40) || (k == 80);
      n_total++;
      if (drop_tick_o !== exp_t) $display("FAIL drop_tick cycle=%0d got=%b exp=%b", k - 1, drop_tick_o, exp_t);
      else n_pass++;
    end
  endtask

  task automatic test_inactive();
    active = 1'b0; raw[0] = 1'b1; raw[4] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_total++;
      if (en_o !== (k == 7)) $display("FAIL en_pulse k=%0d got=%b exp=%b", k, en_o, (k == 7));
      else n_pass++;
      n_total++;
      if (right_o !== 1'b0) $display("FAIL inactive_right k=%0d got=%b exp=0", k, right_o);
      else n_pass++;
    end
    raw[4] = 1'b0; active = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      n_total++;
      if (right_o !== 1'b0) $display("FAIL retro_right k=%0d got=%b exp=0", k, right_o);
      else n_pass++;
    end
    raw = '0;
    for (int k = 1; k <= 12; k++) step();
  endtask

  task automatic test_reset_mid();
    active = 1'b1; raw[1] = 1'b1;
    for (int k = 1; k <= 20; k++) step();
    n_total++;
    if (left_o !== 1'b1) $display("FAIL pre_reset_repeat got=%b exp=1", left_o);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if (w_got !== 6'b0) $display("FAIL async_reset got=%b exp=000000", w_got);
    else n_pass++;
    step(); step(); step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_total++;
      if (left_o !== (k == 7)) $display("FAIL post_reset_press k=%0d got=%b exp=%b", k, left_o, (k == 7));
      else n_pass++;
      n_total++;
      if (w_got !== w_exp) $display("FAIL post_reset_model cyc=%0d got=%b exp=%b", cyc, w_got, w_exp);
      else n_pass++;
    end
    raw = '0;
    for (int k = 1; k <= 12; k++) step();
  endtask

  task automatic test_random();
    for (int s = 0; s < 60; s++) begin
      int len;
      raw    = 5'($urandom_range(0, 31));
      active = ($urandom_range(0, 9) != 0);
      len    = int'($urandom_range(1, 40));
      for (int k = 0; k < len; k++) begin
        step();
        n_total++;
        if (w_got !== w_exp) $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, w_got, w_exp);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate_single();
    test_glitch_repeat();
    test_priority();
    test_drop();
    test_inactive();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
